puf_key_stabilizer: RTL and testbench

Drives one `puf_gen_64` array and consumes its 64-bit raw response. The array is re-excited SAMPLES times, each bit is majority-voted, and the result is presented as a stable 64-bit key with a valid flag. A per-bit unreliability count is reported for health monitoring. The block sits directly downstream of the PUF array and upstream of key consumers in the root-of-trust path.

---
 rtl/puf_pkg.sv | 25 ++
 rtl/puf_bit_vote.sv | 28 ++
 rtl/puf_key_stabilizer.sv | 100 ++++++++++
 tb/tb_puf_key_stabilizer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and defaults for the PUF key stabilizer: FSM state encoding,
// default vote parameters and a constant-foldable clog2.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_RECOVER,
    ST_EVAL,
    ST_DONE
  } stab_state_t;

  localparam int DEF_SAMPLES       = 15;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_MARGIN        = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((32'sd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/puf_bit_vote.sv
// One response bit: saturating ones counter plus majority and margin decisions.
module puf_bit_vote #(
  parameter int SAMPLES = 15,
  parameter int MARGIN  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic bit_in,
  output logic vote,
  output logic stable
);

  logic [7:0] ones;

  always_ff @(posedge clk) begin
    if (reset || clr)
      ones <= '0;
    else if (inc && bit_in && ones != 8'hFF)
      ones <= ones + 8'd1;
  end

  assign vote   = ones > 8'(SAMPLES / 2);
  // Near-unanimous counts in either direction mark a healthy bit.
  assign stable = (ones <= 8'(MARGIN)) || (ones >= 8'(SAMPLES - MARGIN));

endmodule

// File: rtl/puf_key_stabilizer.sv
// Re-excites a PUF array SAMPLES times, majority-votes every bit and presents
// a registered key with a count of bits whose votes fall inside the margin.
module puf_key_stabilizer
  import puf_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int SAMPLES       = DEF_SAMPLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MARGIN        = DEF_MARGIN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    control_input,
  output logic                          puf_enable,
  output logic [1:0]                    puf_control,
  input  logic [WIDTH-1:0]              puf_response,
  output logic [WIDTH-1:0]              key,
  output logic                          key_valid,
  output logic                          busy,
  output logic [clog2(WIDTH+1)-1:0]     unstable_count
);

  localparam int CW  = clog2(WIDTH + 1);
  localparam int SCW = clog2(SETTLE_CYCLES + 1);

  stab_state_t      state, state_nxt;
  logic [SCW-1:0]   settle_cnt;
  logic [7:0]       samp_cnt;
  logic             accept;
  logic [WIDTH-1:0] vote, stable;
  logic [CW-1:0]    unst_sum;

  assign accept = start && (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == SCW'(SETTLE_CYCLES - 1)) state_nxt = ST_SAMPLE;
      ST_SAMPLE:  state_nxt = (samp_cnt == 8'(SAMPLES - 1)) ? ST_EVAL : ST_RECOVER;
      ST_RECOVER: state_nxt = ST_SETTLE;
      ST_EVAL:    state_nxt = ST_DONE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are driven from the next state so they line up with the state edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      puf_enable     <= 1'b0;
      puf_control    <= 2'b00;
      busy           <= 1'b0;
      key            <= '0;
      key_valid      <= 1'b0;
      unstable_count <= '0;
      settle_cnt     <= '0;
      samp_cnt       <= '0;
    end else begin
      puf_enable <= (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);
      busy       <= (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE) ||
                    (state_nxt == ST_RECOVER) || (state_nxt == ST_EVAL);
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SCW'(1) : '0;
      if (accept) begin
        puf_control <= control_input;
        key_valid   <= 1'b0;
        samp_cnt    <= '0;
      end
      if (state == ST_SAMPLE) samp_cnt <= samp_cnt + 8'd1;
      if (state == ST_EVAL) begin
        key            <= vote;
        unstable_count <= unst_sum;
        key_valid      <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    puf_bit_vote #(.SAMPLES(SAMPLES), .MARGIN(MARGIN)) u_vote (
      .clk    (clk),
      .reset  (reset),
      .clr    (accept),
      .inc    (state == ST_SAMPLE),
      .bit_in (puf_response[i]),
      .vote   (vote[i]),
      .stable (stable[i])
    );
  end

  always_comb begin
    unst_sum = '0;
    for (int i = 0; i < WIDTH; i++) unst_sum = unst_sum + CW'(~stable[i]);
  end

endmodule

// File: tb/tb_puf_key_stabilizer.sv
// Scoreboarded bench: expected key/unstable count queued at start, popped at key_valid.
module tb_puf_key_stabilizer;
  import puf_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  control_input = 2'b00;
  logic        puf_enable;
  logic [1:0]  puf_control;
  logic [63:0] puf_response = '0;
  logic [63:0] key;
  logic        key_valid;
  logic        busy;
  logic [6:0]  unstable_count;

  puf_key_stabilizer dut (
    .clk(clk), .reset(reset), .start(start), .control_input(control_input),
    .puf_enable(puf_enable), .puf_control(puf_control), .puf_response(puf_response),
    .key(key), .key_valid(key_valid), .busy(busy), .unstable_count(unstable_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic [63:0] sb_key[$];
  int          sb_unst[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus pattern for sample k (1-based) of the current run.
  logic [63:0] const_resp = '0;
  int          mode = 0;
  function automatic logic [63:0] pattern(input int k);
    logic [63:0] r;
    r = '0;
    if (mode == 0) r = const_resp;
    else begin
      r[0] = (k <= 8);
      r[1] = (k <= 7);
      r[2] = (k <= 2);
      r[3] = (k <= 3);
    end
    return r;
  endfunction

  // Enable waveform monitor; also feeds the response for each pulse.
  bit en_q = 1'b0, busy_q = 1'b0, pchk = 1'b1;
  int pulses = 0, run_pulses = 0, hi_len = 0, low_len = 0;
  always @(negedge clk) begin
    if (busy_q && !busy) run_pulses = pulses;
    if (!busy) pulses = 0;
    if (puf_enable && !en_q) begin
      if (pulses > 0 && pchk) chk("enable_gap", 64'(low_len), 64'd1);
      pulses++;
      hi_len = 1;
      puf_response = pattern(pulses);
    end else if (puf_enable) hi_len++;
    if (!puf_enable && en_q) begin
      if (pchk) chk("enable_width", 64'(hi_len), 64'd9);
      low_len = 1;
    end else if (!puf_enable) low_len++;
    en_q   = puf_enable;
    busy_q = busy;
  end

  task automatic run(input logic [63:0] r, input logic [1:0] ctl, input int md,
                     input bit tog, input logic [63:0] ekey, input int eunst);
    int e0;
    bit got, en_last;
    logic [63:0] k;
    int u;
    const_resp = r;
    mode = md;
    sb_key.push_back(ekey);
    sb_unst.push_back(eunst);
    @(negedge clk);
    start = 1'b1;
    control_input = ctl;
    @(negedge clk);
    e0 = cyc;
    start = 1'b0;
    control_input = ~ctl;
    chk("e0_busy", 64'(busy), 64'd1);
    chk("e0_enable", 64'(puf_enable), 64'd1);
    chk("e0_valid", 64'(key_valid), 64'd0);
    got = 1'b0;
    en_last = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      en_last = puf_enable;
      @(negedge clk);
      if (key_valid) begin
        got = 1'b1;
        start = 1'b0;
      end else begin
        chk("run_ctl", 64'(puf_control), 64'(ctl));
        if (tog) begin
          start = i[0];
          control_input = 2'($urandom);
        end
      end
    end
    chk("valid_seen", 64'(got), 64'd1);
    if (got) begin
      chk("valid_latency", 64'(cyc - e0), 64'd150);
      chk("eval_enable_low", 64'(en_last), 64'd0);
      if (sb_key.size() > 0) begin
        k = sb_key.pop_front();
        u = sb_unst.pop_front();
        chk("key", key, k);
        chk("unstable", 64'(unstable_count), 64'(u));
      end else chk("sb_empty", 64'd1, 64'(sb_key.size()));
      chk("done_ctl", 64'(puf_control), 64'(ctl));
    end
    @(negedge clk);
    chk("pulse_count", 64'(run_pulses), 64'd15);
    chk("done_valid_hold", 64'(key_valid), 64'd1);
    chk("done_enable", 64'(puf_enable), 64'd0);
    chk("done_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(dut.state), 64'(ST_IDLE));
    chk("rst_enable", 64'(puf_enable), 64'd0);
    chk("rst_ctl", 64'(puf_control), 64'd0);
    chk("rst_key", key, 64'd0);
    chk("rst_valid", 64'(key_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_unst", 64'(unstable_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_enable", 64'(puf_enable), 64'd0);

    run(64'hDEADBEEF01234567, 2'b10, 0, 1'b0, 64'hDEADBEEF01234567, 0);
    run(64'h0, 2'b01, 1, 1'b0, 64'h1, 3);
    run(64'hAAAA5555F0F00F0F, 2'b11, 0, 1'b1, 64'hAAAA5555F0F00F0F, 0);

    // Abort mid-run at sample 7.
    const_resp = 64'hFFFF0000FFFF0000;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    control_input = 2'b01;
    @(negedge clk);
    start = 1'b0;
    pchk = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (pulses == 7) hit = 1'b1;
    end
    chk("reach_sample7", 64'(hit), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", 64'(dut.state), 64'(ST_IDLE));
    chk("abort_enable", 64'(puf_enable), 64'd0);
    chk("abort_key", key, 64'd0);
    chk("abort_valid", 64'(key_valid), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_still_invalid", 64'(key_valid), 64'd0);
    pchk = 1'b1;

    run(64'h0123456789ABCDEF, 2'b00, 0, 1'b0, 64'h0123456789ABCDEF, 0);
    run(64'hC3C3C3C3_5A5A5A5A, 2'b10, 0, 1'b0, 64'hC3C3C3C3_5A5A5A5A, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
